// File: rtl/arf_pkg.sv
// Shared constants and types for the arf filter sequencer and its tap bank.
package arf_pkg;

    localparam int ARF_TAPS  = 8;
    localparam int SAMPLE_W  = 16;
    localparam int ACC_W     = 32;
    localparam int TAP_IDX_W = $clog2(ARF_TAPS);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2
    } arf_seq_state_t;

    typedef logic [ARF_TAPS-1:0][SAMPLE_W-1:0] arf_tap_vec_t;

endpackage

// File: rtl/arf_tap_bank.sv
// Eight sample registers feeding the filter taps; one slot written per accepted sample.
module arf_tap_bank
    import arf_pkg::*;
(
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [TAP_IDX_W-1:0] wr_idx,
    input  logic [SAMPLE_W-1:0]  wr_data,
    output arf_tap_vec_t         taps
);

    // Clear wins over a write so a reset mid-frame never leaves a stale slot behind.
    always_ff @(posedge clk) begin
        if (clear) begin
            taps <= '0;
        end else if (wr_en) begin
            taps[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/arf_frame_sequencer.sv
// Collects eight samples into the filter taps, waits out the filter's multicycle
// settle window, then captures and presents the two results as the next recursive state.
module arf_frame_sequencer
    import arf_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] STATE_INIT_A  = 32'd0,
    parameter logic [31:0] STATE_INIT_B  = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        clear_state,
    output logic [15:0] tap_0,
    output logic [15:0] tap_1,
    output logic [15:0] tap_2,
    output logic [15:0] tap_3,
    output logic [15:0] tap_4,
    output logic [15:0] tap_5,
    output logic [15:0] tap_6,
    output logic [15:0] tap_7,
    output logic [31:0] state_a,
    output logic [31:0] state_b,
    input  logic [31:0] res_a_in,
    input  logic [31:0] res_b_in,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_res_a,
    output logic [31:0] m_res_b,
    output logic [15:0] frames_done,
    output logic        busy
);

    localparam logic [1:0] ST_FILL   = FILL;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_OUTPUT = OUTPUT;

    // SETTLE_CYCLES is limited to 1..15, so the countdown fits in four bits.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0]           seq_state;
    logic [TAP_IDX_W-1:0] fill_cnt;
    logic [3:0]           settle_cnt;
    logic [15:0]          frames_q;
    logic                 accept;
    arf_tap_vec_t         taps;

    assign s_ready     = (seq_state == ST_FILL) && !rst;
    assign accept      = s_valid && s_ready;
    assign busy        = (seq_state != ST_FILL) || (fill_cnt != '0);
    assign frames_done = frames_q;

    arf_tap_bank u_tap_bank (
        .clk     (clk),
        .clear   (rst),
        .wr_en   (accept),
        .wr_idx  (fill_cnt),
        .wr_data (s_data),
        .taps    (taps)
    );

    assign tap_0 = taps[0];
    assign tap_1 = taps[1];
    assign tap_2 = taps[2];
    assign tap_3 = taps[3];
    assign tap_4 = taps[4];
    assign tap_5 = taps[5];
    assign tap_6 = taps[6];
    assign tap_7 = taps[7];

    // The taps and state words stay frozen outside FILL; that is what makes the
    // path through the filter to res_*_in a legal multicycle path.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_state  <= ST_FILL;
            fill_cnt   <= '0;
            settle_cnt <= '0;
            state_a    <= STATE_INIT_A;
            state_b    <= STATE_INIT_B;
            m_res_a    <= '0;
            m_res_b    <= '0;
            m_valid    <= 1'b0;
            frames_q   <= '0;
        end else begin
            case (seq_state)
                ST_FILL: begin
                    if (clear_state) begin
                        state_a <= STATE_INIT_A;
                        state_b <= STATE_INIT_B;
                    end
                    if (s_valid) begin
                        if (fill_cnt == TAP_IDX_W'(ARF_TAPS - 1)) begin
                            fill_cnt   <= '0;
                            settle_cnt <= SETTLE_LOAD;
                            seq_state  <= ST_SETTLE;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        m_res_a   <= res_a_in;
                        m_res_b   <= res_b_in;
                        state_a   <= res_a_in;
                        state_b   <= res_b_in;
                        m_valid   <= 1'b1;
                        seq_state <= ST_OUTPUT;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        frames_q  <= frames_q + 16'd1;
                        seq_state <= ST_FILL;
                    end
                end
                default: begin
                    seq_state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: doc/arf_frame_sequencer.md
# arf_frame_sequencer

Upstream sequencer for the `arf_accurate` combinational auto-regressive filter datapath.
- Accepts a serial stream of 16-bit samples over a valid/ready handshake and assembles them into the filter's eight parallel taps.
- Holds the taps stable for a fixed multicycle settle window, then captures the filter's two 32-bit results.
- Presents the results on an output handshake and feeds them back as the recursive state words `state_a`/`state_b` (the filter's `in_13_1`/`in_14_1`).

## Interface
Parameters:
- `SETTLE_CYCLES`, 2: cycles the taps are held before results are captured; legal range 1..15.
- `STATE_INIT_A`, 32'd0: reset/clear value of `state_a`.
- `STATE_INIT_B`, 32'd0: reset/clear value of `state_b`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1: sole clock; all state changes on its rising edge.
  - `rst` input 1: synchronous, active-high reset.
- Sample input handshake:
  - `s_valid` input 1: sample valid.
  - `s_ready` output 1: sequencer can accept a sample.
  - `s_data` input 16: sample.
- `clear_state` input 1: reload `state_a`/`state_b` with their init values.
- `tap_0`..`tap_7` output 16 each: to filter `in_1_0`..`in_8_0`.
- `state_a`, `state_b` output 32: to filter `in_13_1`, `in_14_1`.
- `res_a_in`, `res_b_in` input 32: from filter `out_27`, `out_28`.
- Result output handshake:
  - `m_valid` output 1: result valid.
  - `m_ready` input 1: downstream accepts the result.
  - `m_res_a`, `m_res_b` output 32: captured results.
- `frames_done` output 16: count of completed output handshakes.
- `busy` output 1: high when not in FILL, or when `fill_cnt` != 0.

## Operation
FSM states are FILL, SETTLE and OUTPUT. Reset enters FILL.

Reset values:
- `fill_cnt` = 0; all taps = 0.
- `state_a` = `STATE_INIT_A`, `state_b` = `STATE_INIT_B`.
- `m_res_a` = `m_res_b` = 0; `m_valid` = 0; `frames_done` = 0.
- `s_ready` = 0 while `rst` is high.

FILL:
- `s_ready` = 1.
- On `s_valid && s_ready`, `s_data` is written to `tap[fill_cnt]` and `fill_cnt` increments.
- When the 8th sample is accepted (`fill_cnt` == 7): `fill_cnt` returns to 0, the settle counter loads `SETTLE_CYCLES-1`, and the FSM moves to SETTLE.

SETTLE:
- `s_ready` = 0; taps and state words are frozen.
- The settle counter decrements each cycle.
- On the edge where it reads 0:
  - `res_a_in`/`res_b_in` are captured into `m_res_a`/`m_res_b` and into `state_a`/`state_b`.
  - `m_valid` goes to 1 and the FSM moves to OUTPUT.

OUTPUT:
- `s_ready` = 0; `m_valid` and `m_res_*` are held stable until `m_ready` is seen.
- On `m_valid && m_ready`: `m_valid` goes to 0, `frames_done` increments (0xFFFF wraps to 0x0000), and the FSM returns to FILL.

Taps are not cleared between frames; each new sample overwrites its slot.

`clear_state`:
- Honoured only in FILL; ignored in SETTLE and OUTPUT.
- If it coincides with acceptance of the 8th sample, the clear takes effect and the frame settles with the init state.

Arithmetic: no arithmetic in this block. Results pass through at full 32-bit width, with no truncation and no sign handling.

`rst` mid-frame: partial taps are zeroed, the frame is discarded, `m_valid` drops at the same edge, and no handshake is counted.

## Timing
- `s_ready`, `m_valid` and `busy` are functions of registered state only; there are no combinational paths from `s_valid`/`m_ready`.
- `m_valid` rises exactly `SETTLE_CYCLES` edges after the edge accepting the 8th sample.
- With `SETTLE_CYCLES` = 2, the 8th sample accepted at edge E0 gives capture and `m_valid` = 1 at edge E0+2.
- `m_ready` held high: the handshake completes at the first edge with `m_valid` = 1, and `s_ready` = 1 in the following cycle.
- Minimum frame period is 8 + `SETTLE_CYCLES` + 1 cycles.
- `s_valid` gaps stall FILL without losing `fill_cnt`.
- The filter datapath between the tap/state registers and the `res_*_in` capture is a multicycle path of `SETTLE_CYCLES` cycles; constrain it accordingly.

## Structure
- Shared package `arf_pkg` holds:
  - `ARF_TAPS` = 8, `SAMPLE_W` = 16, `ACC_W` = 32.
  - `arf_seq_state_t` enum {FILL, SETTLE, OUTPUT}.
  - Typedef `arf_tap_vec_t` (8 x 16-bit).
- One natural sub-module, `arf_tap_bank`: eight 16-bit registers with index write-enable and synchronous clear.
- FSM, settle counter, result/state registers and frame counter live in the top.

## Test plan
The bench uses a stub filter with `res_a_in` = sum of taps + `state_a` and `res_b_in` = `state_b` + 1.
- Reset, then stream samples 1..8 with `m_ready`=1 -> `m_valid` at E0+2 with `m_res_a`=36, `m_res_b`=1; `state_a`=36; `frames_done`=1.
- Second frame 1..8 with no clear -> `m_res_a`=72, `m_res_b`=2; assert `clear_state` in FILL, then a third frame 1..8 -> `m_res_a`=36, `m_res_b`=1.
- `s_valid` toggling every other cycle plus `m_ready` held low 5 cycles:
  - Taps are correct and `m_valid`/`m_res_*` stay stable.
  - `s_ready` stays 0 until the handshake.
- `rst` asserted after 5 samples -> taps 0, `busy`=0, `fill_cnt`=0; then a full frame of 8x 16'hFFFF -> `m_res_a`=32'h0007FFF8.
- `SETTLE_CYCLES`=1, `SETTLE_CYCLES`=15 -> `m_valid` exactly 1 and 15 edges after the 8th accept.
- Preload 65535 frames, then one more -> `frames_done` wraps to 0x0000.
